// File: rtl/spi_wb_pkg.sv
// Shared parameters, FSM encoding and pointer helper for the SPI-to-RAM frame writer.
package spi_wb_pkg;

  localparam int unsigned FRAME_W = 42;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PTR_W   = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StWrite = 2'd2
  } state_e;

  // Full when indices match but the wrap bits differ.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
    return (wr[PTR_W-2:0] == rd[PTR_W-2:0]) && (wr[PTR_W-1] != rd[PTR_W-1]);
  endfunction

endpackage

// File: rtl/spi_ram_writer_if.sv
// SPI input pins, reader pointer and RAM port-A write bus of the frame writer.
interface spi_ram_writer_if #(
  parameter int unsigned FRAME_W = spi_wb_pkg::FRAME_W,
  parameter int unsigned PTR_W   = spi_wb_pkg::PTR_W
);

  logic               spi_sck;
  logic               spi_cs_n;
  logic               spi_mosi;
  logic [PTR_W-1:0]   rd_ptr;
  logic               ena;
  logic               wea;
  logic [PTR_W-1:0]   addra;
  logic [FRAME_W-1:0] dia;
  logic [PTR_W-1:0]   wr_ptr;
  logic               frame_done;
  logic               ovf;
  logic               short_err;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, rd_ptr,
    input  ena, wea, addra, dia, wr_ptr, frame_done, ovf, short_err
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, rd_ptr,
    output ena, wea, addra, dia, wr_ptr, frame_done, ovf, short_err
  );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizers for the SPI pins plus rising-edge detect on the synchronized sck.
module spi_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic cs_n_o,
  output logic mosi_o
);

  logic [1:0] sck_q;
  logic [1:0] cs_n_q;
  logic [1:0] mosi_q;
  logic       sck_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q      <= 2'b00;
      cs_n_q     <= 2'b11;
      mosi_q     <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck_i};
      cs_n_q     <= {cs_n_q[0], cs_n_i};
      mosi_q     <= {mosi_q[0], mosi_i};
      sck_prev_q <= sck_q[1];
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_prev_q;
  assign cs_n_o     = cs_n_q[1];
  assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/spi_ram_writer.sv
// Deserializes SPI frames and commits each one to a circular RAM buffer through port A.
module spi_ram_writer #(
  parameter int unsigned FRAME_W = spi_wb_pkg::FRAME_W,
  parameter int unsigned DEPTH   = spi_wb_pkg::DEPTH
) (
  input logic             clk,
  input logic             rst,
  spi_ram_writer_if.slave bus
);

  import spi_wb_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] LastBit = CW'(FRAME_W - 1);

  logic sck_rise, cs_n_s, mosi_s;

  spi_sync u_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .sck_i      (bus.spi_sck),
    .cs_n_i     (bus.spi_cs_n),
    .mosi_i     (bus.spi_mosi),
    .sck_rise_o (sck_rise),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s)
  );

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]         settle_q;
  logic               armed_q;
  logic               full, last_bit;

  logic               ena, wea, frame_done, ovf, short_err;
  logic [PTR_W-1:0]   addra;
  logic [FRAME_W-1:0] dia;

  assign full     = ptr_full(wr_ptr_q, bus.rd_ptr);
  assign last_bit = sck_rise && (cnt_q == LastBit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arming waits until the synchronizer holds real pin values and cs_n has been seen high,
  // so a chip select still low from before reset cannot start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && cs_n_s) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    wr_ptr_d = wr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_n_s && armed_q) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        // A completing edge wins over a simultaneous cs_n release.
        if (last_bit) begin
          state_d = StWrite;
          shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
        end else if (cs_n_s) begin
          state_d = StIdle;
        end else if (sck_rise) begin
          shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        if (!full) wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
        if (cs_n_s) begin
          state_d = StIdle;
        end else begin
          state_d = StShift;
          if (sck_rise) begin
            cnt_d   = CW'(1);
            shreg_d = {{(FRAME_W-1){1'b0}}, mosi_s};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ena        = 1'b0;
    wea        = 1'b0;
    addra      = '0;
    dia        = '0;
    frame_done = 1'b0;
    ovf        = 1'b0;
    short_err  = 1'b0;
    if (!rst) begin
      addra = {{(PTR_W-AW){1'b0}}, wr_ptr_q[AW-1:0]};
      unique case (state_q)
        StWrite: begin
          if (full) begin
            ovf = 1'b1;
          end else begin
            ena        = 1'b1;
            wea        = 1'b1;
            dia        = shreg_q;
            frame_done = 1'b1;
          end
        end
        StShift: short_err = !last_bit && cs_n_s && (cnt_q != '0);
        default: ;
      endcase
    end
  end

  assign bus.ena        = ena;
  assign bus.wea        = wea;
  assign bus.addra      = addra;
  assign bus.dia        = dia;
  assign bus.wr_ptr     = rst ? '0 : wr_ptr_q;
  assign bus.frame_done = frame_done;
  assign bus.ovf        = ovf;
  assign bus.short_err  = short_err;

endmodule

// File: tb/tb_spi_ram_writer.sv
// Self-checking bench: SPI master stimulus against a circular-buffer occupancy model.
module tb_spi_ram_writer;
  import spi_wb_pkg::*;

  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_writer_if bus_if ();

  spi_ram_writer #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]         obs_addr[$];
  logic [FRAME_W-1:0] obs_data[$];
  logic [4:0]         exp_addr[$];
  logic [FRAME_W-1:0] exp_data[$];
  int obs_fd = 0, obs_ovf = 0, obs_se = 0, bad_en = 0;
  int exp_ovf = 0, exp_se = 0;
  int m_wr = 0, m_rd = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.wea === 1'b1) begin
        obs_addr.push_back(bus_if.addra);
        obs_data.push_back(bus_if.dia);
      end
      if (bus_if.frame_done === 1'b1) obs_fd++;
      if (bus_if.ovf === 1'b1) obs_ovf++;
      if (bus_if.short_err === 1'b1) obs_se++;
      if (bus_if.ena !== bus_if.wea || bus_if.frame_done !== bus_if.wea) bad_en++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    obs_fd = 0; obs_ovf = 0; obs_se = 0; exp_ovf = 0; exp_se = 0;
  endtask

  // Occupancy is wr-rd modulo twice the depth; a full buffer drops the frame.
  task automatic model_frame(input logic [FRAME_W-1:0] d);
    int occ;
    occ = (m_wr - m_rd + 32) % 32;
    if (occ == DEPTH) begin
      exp_ovf++;
    end else begin
      exp_addr.push_back(5'(m_wr % DEPTH));
      exp_data.push_back(d);
      m_wr = (m_wr + 1) % 32;
    end
  endtask

  task automatic set_rd(input int rd);
    m_rd = rd % 32;
    bus_if.rd_ptr = 5'(m_rd);
  endtask

  task automatic spi_bit(input logic b);
    bus_if.spi_mosi = b;
    wait_clk(HALF);
    bus_if.spi_sck = 1'b1;
    wait_clk(HALF);
    bus_if.spi_sck = 1'b0;
  endtask

  task automatic send_word(input logic [FRAME_W-1:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(d[i]);
  endtask

  task automatic cs_assert();
    bus_if.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_release();
    wait_clk(HALF);
    bus_if.spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic send_frame(input logic [FRAME_W-1:0] d);
    cs_assert();
    send_word(d, FRAME_W);
    cs_release();
    model_frame(d);
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FRAME_W-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    n_checks++;
    if ({bus_if.ena, bus_if.wea, bus_if.frame_done, bus_if.ovf, bus_if.short_err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b want 00000", {bus_if.ena, bus_if.wea,
               bus_if.frame_done, bus_if.ovf, bus_if.short_err});
    end
    n_checks++;
    if (bus_if.addra !== 5'd0 || bus_if.wr_ptr !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_ptrs: addra=%0d wr_ptr=%0d want 0 0", bus_if.addra, bus_if.wr_ptr);
    end
    n_checks++;
    if (bus_if.dia !== '0) begin
      n_errors++;
      $display("FAIL reset_dia: got %h want 0", bus_if.dia);
    end
    rst = 1'b0;
    wait_clk(6);
    n_checks++;
    if (bus_if.wr_ptr !== 5'd0 || bus_if.wea !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset: wr_ptr=%0d wea=%b want 0 0", bus_if.wr_ptr, bus_if.wea);
    end
    m_wr = 0;
    set_rd(0);
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(42'h2AA_AAAA_AAAA);
    n_checks++;
    if (obs_addr.size() != 1) begin
      n_errors++;
      $display("FAIL single_count: got %0d writes want 1", obs_addr.size());
    end else begin
      n_checks++;
      if (obs_addr[0] !== 5'd0 || obs_data[0] !== 42'h2AA_AAAA_AAAA) begin
        n_errors++;
        $display("FAIL single_write: got a=%0d d=%h want a=0 d=2aaaaaaaaaa", obs_addr[0],
                 obs_data[0]);
      end
    end
    n_checks++;
    if (bus_if.wr_ptr !== 5'd1 || obs_fd != 1) begin
      n_errors++;
      $display("FAIL single_ptr: wr_ptr=%0d done=%0d want 1 1", bus_if.wr_ptr, obs_fd);
    end
  endtask

  task automatic test_fill_ovf();
    clear_obs();
    for (int i = 0; i < 15; i++) send_frame(rand_frame());
    n_checks++;
    if (bus_if.wr_ptr !== 5'b10000) begin
      n_errors++;
      $display("FAIL fill_ptr: got %b want 10000", bus_if.wr_ptr);
    end
    n_checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_errors++;
      $display("FAIL fill_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_errors++;
          $display("FAIL fill_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, obs_addr[i],
                   obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    clear_obs();
    send_frame(rand_frame());
    n_checks++;
    if (obs_ovf != 1 || obs_addr.size() != 0 || bus_if.wr_ptr !== 5'b10000) begin
      n_errors++;
      $display("FAIL overflow: ovf=%0d writes=%0d wr_ptr=%b want 1 0 10000", obs_ovf,
               obs_addr.size(), bus_if.wr_ptr);
    end
  endtask

  task automatic test_release();
    logic [FRAME_W-1:0] d;
    clear_obs();
    set_rd(1);
    d = rand_frame();
    send_frame(d);
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 5'd0 || obs_data[0] !== d) begin
      n_errors++;
      $display("FAIL release_write: writes=%0d want one at a=0 d=%h", obs_addr.size(), d);
    end
    n_checks++;
    if (bus_if.wr_ptr !== 5'b10001 || obs_ovf != 0) begin
      n_errors++;
      $display("FAIL release_ptr: wr_ptr=%b ovf=%0d want 10001 0", bus_if.wr_ptr, obs_ovf);
    end
    set_rd(m_wr);
  endtask

  task automatic test_short();
    logic [FRAME_W-1:0] d;
    clear_obs();
    cs_assert();
    send_word(rand_frame(), 20);
    cs_release();
    n_checks++;
    if (obs_se != 1 || obs_addr.size() != 0) begin
      n_errors++;
      $display("FAIL short_20: short_err=%0d writes=%0d want 1 0", obs_se, obs_addr.size());
    end
    cs_assert();
    cs_release();
    n_checks++;
    if (obs_se != 1) begin
      n_errors++;
      $display("FAIL short_zero: short_err=%0d want 1", obs_se);
    end
    d = rand_frame();
    send_frame(d);
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== d) begin
      n_errors++;
      $display("FAIL short_next: writes=%0d want one at a=%0d d=%h", obs_addr.size(),
               exp_addr[0], d);
    end
  endtask

  task automatic test_back_to_back();
    logic [FRAME_W-1:0] d0, d1;
    clear_obs();
    d0 = rand_frame();
    d1 = rand_frame();
    cs_assert();
    send_word(d0, FRAME_W);
    send_word(d1, FRAME_W);
    cs_release();
    model_frame(d0);
    model_frame(d1);
    n_checks++;
    if (obs_addr.size() != 2) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d writes want 2", obs_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_errors++;
          $display("FAIL b2b_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, obs_addr[i],
                   obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [FRAME_W-1:0] d;
    clear_obs();
    cs_assert();
    send_word(rand_frame(), 30);
    rst = 1'b1;
    set_rd(0);
    m_wr = 0;
    wait_clk(3);
    n_checks++;
    if ({bus_if.ena, bus_if.wea, bus_if.short_err, bus_if.wr_ptr, bus_if.addra} !== 13'b0 ||
        bus_if.dia !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: ena=%b wea=%b se=%b wr=%0d a=%0d dia=%h want all 0",
               bus_if.ena, bus_if.wea, bus_if.short_err, bus_if.wr_ptr, bus_if.addra,
               bus_if.dia);
    end
    rst = 1'b0;
    // Bits still clocked under the stale chip select must not form a frame.
    send_word(rand_frame(), 12);
    cs_release();
    d = rand_frame();
    send_frame(d);
    n_checks++;
    if (obs_se != 0) begin
      n_errors++;
      $display("FAIL midrst_short: short_err=%0d want 0", obs_se);
    end
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 5'd0 || obs_data[0] !== d) begin
      n_errors++;
      $display("FAIL midrst_write: writes=%0d want one at a=0 d=%h", obs_addr.size(), d);
    end
  endtask

  task automatic test_random();
    logic [FRAME_W-1:0] d0, d1;
    int kind, n;
    clear_obs();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) set_rd(m_rd + $urandom_range(0, (m_wr - m_rd + 32) % 32));
      kind = $urandom_range(0, 4);
      d0 = rand_frame();
      d1 = rand_frame();
      if (kind == 0) begin
        n = $urandom_range(1, FRAME_W - 1);
        cs_assert();
        send_word(d0, n);
        cs_release();
        exp_se++;
      end else if (kind == 1) begin
        cs_assert();
        send_word(d0, FRAME_W);
        send_word(d1, FRAME_W);
        cs_release();
        model_frame(d0);
        model_frame(d1);
      end else begin
        send_frame(d0);
      end
    end
    n_checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_errors++;
      $display("FAIL rand_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          n_errors++;
          $display("FAIL rand_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, obs_addr[i],
                   obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    n_checks++;
    if (obs_ovf != exp_ovf || obs_se != exp_se || obs_fd != exp_addr.size()) begin
      n_errors++;
      $display("FAIL rand_pulses: ovf=%0d se=%0d done=%0d want %0d %0d %0d", obs_ovf, obs_se,
               obs_fd, exp_ovf, exp_se, exp_addr.size());
    end
    n_checks++;
    if (bus_if.wr_ptr !== 5'(m_wr)) begin
      n_errors++;
      $display("FAIL rand_ptr: got %0d want %0d", bus_if.wr_ptr, m_wr);
    end
    n_checks++;
    if (bad_en != 0) begin
      n_errors++;
      $display("FAIL strobe_align: %0d cycles with ena/wea/frame_done disagreeing", bad_en);
    end
  endtask

  initial begin
    bus_if.spi_sck  = 1'b0;
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_mosi = 1'b0;
    bus_if.rd_ptr   = 5'd0;
    test_reset();
    test_single();
    test_fill_ovf();
    test_release();
    test_short();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
